// File: rtl/phold_mc_bridge.sv
// Request/response buffering bridge between phold's arbitrated MC port and one Convey MC port.
// Flushes wait in the request FIFO until every issued request has been answered.
module phold_mc_bridge #(
  parameter int unsigned MC_RTNCTL_WIDTH = 32,
  parameter int unsigned RQ_DEPTH        = 16,
  parameter int unsigned RS_DEPTH        = 16,
  parameter int unsigned STALL_MARGIN    = 4,
  parameter int unsigned OUT_W           = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       up_rq_vld,
  input  logic [2:0]                 up_rq_cmd,
  input  logic [3:0]                 up_rq_scmd,
  input  logic [47:0]                up_rq_vadr,
  input  logic [1:0]                 up_rq_size,
  input  logic [MC_RTNCTL_WIDTH-1:0] up_rq_rtnctl,
  input  logic [63:0]                up_rq_data,
  input  logic                       up_rq_flush,
  output logic                       up_rq_stall,
  output logic                       mc_rq_vld,
  output logic [2:0]                 mc_rq_cmd,
  output logic [3:0]                 mc_rq_scmd,
  output logic [47:0]                mc_rq_vadr,
  output logic [1:0]                 mc_rq_size,
  output logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  output logic [63:0]                mc_rq_data,
  output logic                       mc_rq_flush,
  input  logic                       mc_rq_stall,
  input  logic                       mc_rs_vld,
  input  logic [2:0]                 mc_rs_cmd,
  input  logic [3:0]                 mc_rs_scmd,
  input  logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
  input  logic [63:0]                mc_rs_data,
  output logic                       mc_rs_stall,
  output logic                       up_rs_vld,
  output logic [2:0]                 up_rs_cmd,
  output logic [3:0]                 up_rs_scmd,
  output logic [MC_RTNCTL_WIDTH-1:0] up_rs_rtnctl,
  output logic [63:0]                up_rs_data,
  input  logic                       up_rs_stall,
  output logic                       idle,
  output logic [1:0]                 err
);

  localparam int unsigned RqAw = $clog2(RQ_DEPTH);
  localparam int unsigned RsAw = $clog2(RS_DEPTH);
  localparam int unsigned RqEw = 1 + 3 + 4 + 48 + 2 + MC_RTNCTL_WIDTH + 64;
  localparam int unsigned RsEw = 3 + 4 + MC_RTNCTL_WIDTH + 64;
  localparam logic [RqAw:0] RqFull = (RqAw+1)'(RQ_DEPTH);
  localparam logic [RqAw:0] RqHigh = (RqAw+1)'(RQ_DEPTH - STALL_MARGIN);
  localparam logic [RsAw:0] RsFull = (RsAw+1)'(RS_DEPTH);
  localparam logic [RsAw:0] RsHigh = (RsAw+1)'(RS_DEPTH - STALL_MARGIN);

  typedef enum logic {StRun, StDrain} state_e;

  state_e r_state, w_state_d;

  logic [RqEw-1:0] r_rq_mem [RQ_DEPTH];
  logic [RqAw-1:0] r_rq_wr, r_rq_rd;
  logic [RqAw:0]   r_rq_cnt;
  logic [RsEw-1:0] r_rs_mem [RS_DEPTH];
  logic [RsAw-1:0] r_rs_wr, r_rs_rd;
  logic [RsAw:0]   r_rs_cnt;
  logic [OUT_W-1:0] r_out;
  logic [1:0]      r_err;

  logic                       r_mc_vld, r_mc_flush;
  logic [2:0]                 r_mc_cmd;
  logic [3:0]                 r_mc_scmd;
  logic [47:0]                r_mc_vadr;
  logic [1:0]                 r_mc_size;
  logic [MC_RTNCTL_WIDTH-1:0] r_mc_rtnctl;
  logic [63:0]                r_mc_data;
  logic                       r_up_vld;
  logic [RsEw-1:0]            r_up_rs;

  logic                       w_h_flush;
  logic [2:0]                 w_h_cmd;
  logic [3:0]                 w_h_scmd;
  logic [47:0]                w_h_vadr;
  logic [1:0]                 w_h_size;
  logic [MC_RTNCTL_WIDTH-1:0] w_h_rtnctl;
  logic [63:0]                w_h_data;

  logic w_issue, w_flush_fire, w_rq_pop, w_rq_push, w_rq_push_ok;
  logic w_rs_pop, w_rs_push_ok, w_underflow;

  assign {w_h_flush, w_h_cmd, w_h_scmd, w_h_vadr, w_h_size, w_h_rtnctl, w_h_data} =
      r_rq_mem[r_rq_rd];

  assign w_rq_push    = up_rq_vld | up_rq_flush;
  assign w_rq_push_ok = w_rq_push & (r_rq_cnt != RqFull);
  assign w_rq_pop     = w_issue | w_flush_fire;
  assign w_rs_push_ok = mc_rs_vld & (r_rs_cnt != RsFull);
  assign w_rs_pop     = (r_rs_cnt != '0) & ~up_rs_stall;
  assign w_underflow  = mc_rs_vld & ~w_issue & (r_out == '0);

  always_comb begin
    w_state_d    = r_state;
    w_issue      = 1'b0;
    w_flush_fire = 1'b0;
    unique case (r_state)
      StRun: begin
        if (r_rq_cnt != '0) begin
          if (w_h_flush) w_state_d = StDrain;
          else if (!mc_rq_stall) w_issue = 1'b1;
        end
      end
      StDrain: begin
        // The flush sits at the head until every issued request has been answered.
        if (r_out == '0 && !mc_rq_stall) begin
          w_flush_fire = 1'b1;
          w_state_d    = StRun;
        end
      end
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rq_push_ok) begin
      r_rq_mem[r_rq_wr] <= {up_rq_flush, up_rq_cmd, up_rq_scmd, up_rq_vadr, up_rq_size,
                            up_rq_rtnctl, up_rq_data};
    end
    if (w_rs_push_ok) r_rs_mem[r_rs_wr] <= {mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StRun;
      r_rq_wr  <= '0;
      r_rq_rd  <= '0;
      r_rq_cnt <= '0;
      r_rs_wr  <= '0;
      r_rs_rd  <= '0;
      r_rs_cnt <= '0;
      r_out    <= '0;
      r_err    <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_rq_push_ok) r_rq_wr <= r_rq_wr + RqAw'(1);
      if (w_rq_pop)     r_rq_rd <= r_rq_rd + RqAw'(1);
      if (w_rq_push_ok && !w_rq_pop)      r_rq_cnt <= r_rq_cnt + (RqAw+1)'(1);
      else if (!w_rq_push_ok && w_rq_pop) r_rq_cnt <= r_rq_cnt - (RqAw+1)'(1);
      if (w_rs_push_ok) r_rs_wr <= r_rs_wr + RsAw'(1);
      if (w_rs_pop)     r_rs_rd <= r_rs_rd + RsAw'(1);
      if (w_rs_push_ok && !w_rs_pop)      r_rs_cnt <= r_rs_cnt + (RsAw+1)'(1);
      else if (!w_rs_push_ok && w_rs_pop) r_rs_cnt <= r_rs_cnt - (RsAw+1)'(1);
      if (w_issue && !mc_rs_vld && r_out != {OUT_W{1'b1}}) r_out <= r_out + OUT_W'(1);
      else if (mc_rs_vld && !w_issue && r_out != '0)      r_out <= r_out - OUT_W'(1);
      if ((w_rq_push && !w_rq_push_ok) || (mc_rs_vld && !w_rs_push_ok)) r_err[0] <= 1'b1;
      if (w_underflow) r_err[1] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mc_vld    <= 1'b0;
      r_mc_flush  <= 1'b0;
      r_mc_cmd    <= '0;
      r_mc_scmd   <= '0;
      r_mc_vadr   <= '0;
      r_mc_size   <= '0;
      r_mc_rtnctl <= '0;
      r_mc_data   <= '0;
      r_up_vld    <= 1'b0;
      r_up_rs     <= '0;
    end else begin
      r_mc_vld   <= w_issue;
      r_mc_flush <= w_flush_fire;
      if (w_issue) begin
        r_mc_cmd    <= w_h_cmd;
        r_mc_scmd   <= w_h_scmd;
        r_mc_vadr   <= w_h_vadr;
        r_mc_size   <= w_h_size;
        r_mc_rtnctl <= w_h_rtnctl;
        r_mc_data   <= w_h_data;
      end
      r_up_vld <= w_rs_pop;
      if (w_rs_pop) r_up_rs <= r_rs_mem[r_rs_rd];
    end
  end

  assign up_rq_stall  = (r_rq_cnt >= RqHigh);
  assign mc_rs_stall  = (r_rs_cnt >= RsHigh);
  assign mc_rq_vld    = r_mc_vld;
  assign mc_rq_flush  = r_mc_flush;
  assign mc_rq_cmd    = r_mc_cmd;
  assign mc_rq_scmd   = r_mc_scmd;
  assign mc_rq_vadr   = r_mc_vadr;
  assign mc_rq_size   = r_mc_size;
  assign mc_rq_rtnctl = r_mc_rtnctl;
  assign mc_rq_data   = r_mc_data;
  assign up_rs_vld    = r_up_vld;
  assign {up_rs_cmd, up_rs_scmd, up_rs_rtnctl, up_rs_data} = r_up_rs;
  assign err          = r_err;
  assign idle = (r_rq_cnt == '0) & (r_rs_cnt == '0) & (r_out == '0) & ~r_mc_vld & ~r_up_vld &
                (r_state == StRun);

endmodule

// File: tb/tb_phold_mc_bridge.sv
// Randomized bench for phold_mc_bridge, checked against a queue-based model of the bridge.
module tb_phold_mc_bridge;
  localparam int W = 32;
  localparam int RQD = 16;
  localparam int RSD = 16;
  localparam int MARGIN = 4;
  localparam int OUT_MAX = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic up_rq_vld = 0, up_rq_flush = 0, mc_rq_stall = 0, mc_rs_vld = 0, up_rs_stall = 0;
  logic [2:0] up_rq_cmd = 0, mc_rs_cmd = 0;
  logic [3:0] up_rq_scmd = 0, mc_rs_scmd = 0;
  logic [47:0] up_rq_vadr = 0;
  logic [1:0] up_rq_size = 0;
  logic [W-1:0] up_rq_rtnctl = 0, mc_rs_rtnctl = 0;
  logic [63:0] up_rq_data = 0, mc_rs_data = 0;
  logic up_rq_stall, mc_rq_vld, mc_rq_flush, mc_rs_stall, up_rs_vld, idle;
  logic [2:0] mc_rq_cmd, up_rs_cmd;
  logic [3:0] mc_rq_scmd, up_rs_scmd;
  logic [47:0] mc_rq_vadr;
  logic [1:0] mc_rq_size, err;
  logic [W-1:0] mc_rq_rtnctl, up_rs_rtnctl;
  logic [63:0] mc_rq_data, up_rs_data;

  phold_mc_bridge #(.MC_RTNCTL_WIDTH(W), .RQ_DEPTH(RQD), .RS_DEPTH(RSD),
                    .STALL_MARGIN(MARGIN), .OUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_rq_vld(up_rq_vld), .up_rq_cmd(up_rq_cmd), .up_rq_scmd(up_rq_scmd),
    .up_rq_vadr(up_rq_vadr), .up_rq_size(up_rq_size), .up_rq_rtnctl(up_rq_rtnctl),
    .up_rq_data(up_rq_data), .up_rq_flush(up_rq_flush), .up_rq_stall(up_rq_stall),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
    .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data), .mc_rs_stall(mc_rs_stall),
    .up_rs_vld(up_rs_vld), .up_rs_cmd(up_rs_cmd), .up_rs_scmd(up_rs_scmd),
    .up_rs_rtnctl(up_rs_rtnctl), .up_rs_data(up_rs_data), .up_rs_stall(up_rs_stall),
    .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] cmd; logic [3:0] scmd; logic [47:0] vadr; logic [1:0] size;
    logic [W-1:0] rtnctl; logic [63:0] data;
  } rq_t;
  typedef struct packed { logic flush; rq_t f; } rq_ent_t;
  typedef struct packed {
    logic [2:0] cmd; logic [3:0] scmd; logic [W-1:0] rtnctl; logic [63:0] data;
  } rs_t;

  // Reference model: FIFOs as queues, outstanding as an integer.
  rq_ent_t m_rq[$];
  rs_t     m_rs[$];
  int      m_out = 0;
  bit      m_drain = 0;
  bit      e_mc_vld = 0, e_mc_flush = 0, e_up_vld = 0;
  rq_t     e_mc = '0;
  rs_t     e_up = '0;
  logic [1:0] e_err = 2'b00;

  int n_checks = 0;
  int n_fail = 0;
  int seq = 0;

  always @(posedge clk or negedge rst_n) begin
    bit issue, fire, rs_pop, rq_full, rs_full;
    rq_ent_t n;
    rs_t r;
    if (!rst_n) begin
      m_rq.delete(); m_rs.delete();
      m_out = 0; m_drain = 0; e_mc_vld = 0; e_mc_flush = 0; e_up_vld = 0;
      e_mc = '0; e_up = '0; e_err = 2'b00;
    end else begin
      rq_full = (m_rq.size() == RQD);
      rs_full = (m_rs.size() == RSD);
      issue = 0;
      fire = 0;
      if (m_drain) fire = (m_out == 0) && !mc_rq_stall;
      else if (m_rq.size() > 0) begin
        if (m_rq[0].flush) m_drain = 1;
        else issue = !mc_rq_stall;
      end
      rs_pop = (m_rs.size() > 0) && !up_rs_stall;
      e_mc_vld = issue;
      e_mc_flush = fire;
      if (issue) begin e_mc = m_rq[0].f; void'(m_rq.pop_front()); end
      if (fire) begin void'(m_rq.pop_front()); m_drain = 0; end
      if (up_rq_vld || up_rq_flush) begin
        if (rq_full) e_err[0] = 1'b1;
        else begin
          n.flush = up_rq_flush; n.f.cmd = up_rq_cmd; n.f.scmd = up_rq_scmd;
          n.f.vadr = up_rq_vadr; n.f.size = up_rq_size; n.f.rtnctl = up_rq_rtnctl;
          n.f.data = up_rq_data;
          m_rq.push_back(n);
        end
      end
      if (issue && !mc_rs_vld) m_out = (m_out == OUT_MAX) ? OUT_MAX : m_out + 1;
      else if (mc_rs_vld && !issue) begin
        if (m_out == 0) e_err[1] = 1'b1;
        else m_out = m_out - 1;
      end
      e_up_vld = rs_pop;
      if (rs_pop) e_up = m_rs.pop_front();
      if (mc_rs_vld) begin
        if (rs_full) e_err[0] = 1'b1;
        else begin
          r.cmd = mc_rs_cmd; r.scmd = mc_rs_scmd; r.rtnctl = mc_rs_rtnctl; r.data = mc_rs_data;
          m_rs.push_back(r);
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_idle();
    return m_rq.size() == 0 && m_rs.size() == 0 && m_out == 0 && !e_mc_vld && !e_up_vld &&
           !m_drain;
  endfunction

  task automatic compare_all();
    check_eq("mc_rq_ctl", 256'({mc_rq_vld, mc_rq_flush}), 256'({e_mc_vld, e_mc_flush}));
    if (e_mc_vld)
      check_eq("mc_rq_fields", 256'({mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
                                     mc_rq_rtnctl, mc_rq_data}), 256'(e_mc));
    check_eq("up_rs_vld", 256'(up_rs_vld), 256'(e_up_vld));
    if (e_up_vld)
      check_eq("up_rs_fields", 256'({up_rs_cmd, up_rs_scmd, up_rs_rtnctl, up_rs_data}),
               256'(e_up));
    check_eq("up_rq_stall", 256'(up_rq_stall), 256'(m_rq.size() >= RQD - MARGIN));
    check_eq("mc_rs_stall", 256'(mc_rs_stall), 256'(m_rs.size() >= RSD - MARGIN));
    check_eq("idle", 256'(idle), 256'(model_idle()));
    check_eq("err", 256'(err), 256'(e_err));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clr_in();
    up_rq_vld = 0; up_rq_flush = 0; mc_rs_vld = 0;
  endtask

  task automatic push_rq(input logic [2:0] cmd, input logic [47:0] vadr,
                         input logic [W-1:0] rtn, input logic [63:0] data);
    up_rq_vld = 1; up_rq_flush = 0; up_rq_cmd = cmd; up_rq_scmd = 4'($urandom);
    up_rq_vadr = vadr; up_rq_size = 2'($urandom); up_rq_rtnctl = rtn; up_rq_data = data;
  endtask

  task automatic push_flush();
    up_rq_vld = 0; up_rq_flush = 1; up_rq_cmd = 3'($urandom);
  endtask

  task automatic send_rs(input logic [W-1:0] rtn, input logic [63:0] data);
    mc_rs_vld = 1; mc_rs_cmd = 3'($urandom); mc_rs_scmd = 4'($urandom);
    mc_rs_rtnctl = rtn; mc_rs_data = data;
  endtask

  task automatic push_rand();
    push_rq(3'($urandom), {16'($urandom), 32'($urandom)}, W'(seq), {32'($urandom), 32'($urandom)});
    seq++;
  endtask

  // Answers outstanding requests until the model is quiescent, within a cycle budget.
  task automatic drain_all();
    bit done;
    done = 0;
    mc_rq_stall = 0; up_rs_stall = 0; clr_in();
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      clr_in();
      if (model_idle()) done = 1;
      else if (m_out > 0) begin
        send_rs(W'(seq), {32'($urandom), 32'($urandom)});
        seq++;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout got=busy exp=idle");
    end
  endtask

  initial begin
    #12 rst_n = 1;
    // Single read, then its response.
    tick();
    push_rq(3'd1, 48'h1000, W'(5), 64'h0);
    tick(); clr_in();
    tick();
    check_eq("t1_mc_vld", 256'(mc_rq_vld), 256'(1));
    check_eq("t1_vadr", 256'(mc_rq_vadr), 256'(48'h1000));
    tick();
    check_eq("t1_mc_vld_1cyc", 256'(mc_rq_vld), 256'(0));
    send_rs(W'(5), 64'hABCD);
    tick(); clr_in();
    tick();
    check_eq("t1_rs_data", 256'(up_rs_data), 256'(64'hABCD));
    check_eq("t1_rs_rtnctl", 256'(up_rs_rtnctl), 256'(5));
    tick();
    check_eq("t1_idle", 256'(idle), 256'(1));

    // 14 requests behind an MC stall, then release.
    mc_rq_stall = 1;
    for (int i = 0; i < 14; i++) begin
      push_rq(3'd1, 48'(i * 64), W'(100 + i), 64'(i)); tick();
    end
    clr_in(); tick(); tick();
    check_eq("t2_stall", 256'(up_rq_stall), 256'(1));
    check_eq("t2_err", 256'(err), 256'(0));
    mc_rq_stall = 0;
    for (int i = 0; i < 16; i++) tick();
    drain_all();

    // Overflow: 17 pushes into a 16-entry FIFO.
    mc_rq_stall = 1;
    for (int i = 0; i < 17; i++) begin push_rand(); tick(); end
    clr_in(); tick();
    check_eq("t3_err0", 256'(err[0]), 256'(1));
    drain_all();

    // Flush held behind three writes; reads queued behind the flush.
    for (int i = 0; i < 3; i++) begin
      push_rq(3'd2, 48'(32'h2000 + i * 8), W'(200 + i), 64'(i)); tick();
    end
    push_flush(); tick();
    push_rand(); tick();
    push_rand(); tick();
    clr_in();
    for (int i = 0; i < 10; i++) tick();
    for (int i = 0; i < 3; i++) begin send_rs(W'(200 + i), 64'(i)); tick(); end
    clr_in();
    for (int i = 0; i < 8; i++) tick();
    drain_all();

    // 12 responses held by up_rs_stall.
    up_rs_stall = 1;
    for (int i = 0; i < 12; i++) begin push_rand(); tick(); end
    clr_in();
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 12; i++) begin send_rs(W'(i), 64'(i * 3)); tick(); end
    clr_in(); tick();
    check_eq("t5_rs_stall", 256'(mc_rs_stall), 256'(1));
    up_rs_stall = 0;
    for (int i = 0; i < 14; i++) tick();
    drain_all();

    // Spurious response, then an async reset in the middle of traffic.
    send_rs(W'(77), 64'h77); tick(); clr_in(); tick();
    check_eq("t6_err1", 256'(err[1]), 256'(1));
    for (int i = 0; i < 20; i++) begin
      clr_in();
      mc_rq_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) push_rand();
      if (m_out > 0 && $urandom_range(0, 2) == 0) send_rs(W'(seq), 64'($urandom));
      tick();
    end
    #2 rst_n = 0;
    #1;
    check_eq("rst_mc", 256'({mc_rq_vld, mc_rq_flush, mc_rq_rtnctl, mc_rq_data}), 256'(0));
    check_eq("rst_up", 256'({up_rs_vld, up_rs_rtnctl, up_rs_data}), 256'(0));
    check_eq("rst_misc", 256'({up_rq_stall, mc_rs_stall, err}), 256'(0));
    clr_in(); mc_rq_stall = 0; up_rs_stall = 0;
    tick(); tick();
    #2 rst_n = 1;
    tick();
    check_eq("rst_idle", 256'(idle), 256'(1));

    // Random traffic with stalls and flushes.
    for (int i = 0; i < 600; i++) begin
      clr_in();
      mc_rq_stall = ($urandom_range(0, 3) == 0);
      up_rs_stall = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: push_rand();
        5: push_flush();
        default: ;
      endcase
      if (m_out > 0 && $urandom_range(0, 1) == 1) begin
        send_rs(W'(seq), {32'($urandom), 32'($urandom)});
        seq++;
      end
      tick();
    end
    drain_all();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
